dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller.
- Sits in the MEM stage, between the EX/MEM pipeline register and the off-chip data memory.
- Serves 32-bit CPU loads and stores. Refills and evicts whole 256-bit lines through a variable-latency memory handshake.
- Raises stall_o to freeze the whole pipeline while a miss is being serviced.

Parameters:
- NUM_LINES, 16, number of cache lines (power of two); index width IDX_W = log2(NUM_LINES).
- LINE_W, 256, line width in bits (32 bytes); offset width OFF_W = 5.
- ADDR_W, 32, byte address width; tag width TAG_W = ADDR_W - IDX_W - OFF_W (23 at defaults).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_read_i  in  1  load request from the EX/MEM register (MemRead).
- req_write_i  in  1  store request from the EX/MEM register (MemWrite).
- addr_i  in  ADDR_W  byte address; bits [1:0] ignored (word aligned).
- wdata_i  in  32  store data.
- rdata_o  out  32  load data, valid when a request is present and stall_o=0.
- stall_o  out  1  freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while high.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  ADDR_W  line-aligned address (low OFF_W bits zero).
- mem_wdata_o  out  LINE_W  victim line data.
- mem_rdata_i  in  LINE_W  fetched line data, valid in the mem_ack_i cycle.
- mem_ack_i  in  1  one-cycle pulse completing the current memory request.

Behaviour:
- Address split: tag = addr_i[ADDR_W-1:IDX_W+5], index = addr_i[IDX_W+4:5], word = addr_i[4:2].
- Storage: per line a valid bit, a dirty bit, a tag and LINE_W bits of data.
- hit = req && valid[index] && tag match.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: stall_o=0, mem_enable_o=0.
- IDLE, read hit: rdata_o = the selected word, combinationally in the same cycle; stall_o=0; no state change.
- IDLE, write hit: at the clock edge the selected word is replaced by wdata_i and dirty is set; stall_o=0.
- IDLE, miss: stall_o=1 combinationally in the same cycle. Next state is WRITEBACK if the victim is valid and dirty, otherwise ALLOCATE.
- WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, index, 5'b0}, mem_wdata_o = victim line. Outputs held stable until mem_ack_i; on ack go to ALLOCATE.
- ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, index, 5'b0}. On ack: install mem_rdata_i, set valid=1, dirty=0, write the tag, go to IDLE.
- After ALLOCATE returns to IDLE, the still-held request hits. A store completes at that edge and sets dirty.
- Minimum miss penalty: clean miss = memory latency + 1 cycle; dirty miss = 2 x memory latency + 1 cycle.
- stall_o = (state != IDLE) || (req && !hit).
- mem_enable_o deasserts in the cycle after ack. mem_ack_i in IDLE is ignored.
- req_read_i and req_write_i both high: treated as a write; rdata_o still drives the pre-write word.
- Request inputs are required stable while stall_o=1 (the pipeline is frozen). Changes during a miss are not supported.
- Reset (async, asserted low): state=IDLE, all valid and dirty bits=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0.
- Reset mid-miss aborts the transfer; mem_enable_o drops immediately. Data and tag arrays need not be cleared.
- Wrap-around: index and tag are pure bit fields, so address aliasing conflicts are handled by eviction only.

Decomposition:
- Shared package dcache_pkg: the state enum (IDLE, WRITEBACK, ALLOCATE); constants OFF_W=5, WORD_SEL_W=3; field-extract functions for tag, index and word.
- One natural sub-module, dcache_sram: tag/valid/dirty/data arrays with a read port and a write port (line write or word write). The FSM and hit logic stay in dcache_ctrl.

Test Plan:
- Reset then read 0x0000_0100: stall_o=1 the same cycle; ALLOCATE request with addr 0x0000_0100; ack after 10 cycles with line word2=0xDEADBEEF; a read of 0x108 then returns 0xDEADBEEF with stall_o=0.
- Write hit: after the first test, write 0x0000_0104=0x12345678. No memory request; an immediate read of 0x104 returns 0x12345678; the line is dirty.
- Dirty eviction: read 0x0000_2104 (same index 8, new tag). Expect WRITEBACK to addr 0x0000_0100 with mem_wdata_o word1=0x12345678, then ALLOCATE to 0x0000_2100; stall_o lasts 2 x latency + 1 cycles.
- Clean eviction: read 0x0000_4104 after loading 0x2104 clean. Expect no WRITEBACK, a single ALLOCATE to 0x0000_4100.
- Simultaneous read+write to 0x108 with wdata 0xA5A5A5A5: treated as a store; a subsequent read returns 0xA5A5A5A5.
- Reset asserted during ALLOCATE wait: mem_enable_o=0 and stall_o=0 asynchronously. After release, a read of the same address misses again (valid cleared).

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back L1 data cache:
// controller states, address-field constants and field-extract helpers.
package dcache_pkg;

   localparam int OFF_W      = 5;
   localparam int WORD_SEL_W = 3;
   localparam int FIELD_W    = 64;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE
   } state_e;

   // Helpers work on a zero-extended address and return right-justified fields.
   function automatic logic [FIELD_W-1:0] addr_tag(input logic [FIELD_W-1:0] addr,
                                                   input int idx_w);
      return addr >> (idx_w + OFF_W);
   endfunction

   function automatic logic [FIELD_W-1:0] addr_index(input logic [FIELD_W-1:0] addr,
                                                     input int idx_w);
      logic [FIELD_W-1:0] mask;
      mask = (FIELD_W'(1) << idx_w) - FIELD_W'(1);
      return (addr >> OFF_W) & mask;
   endfunction

   function automatic logic [FIELD_W-1:0] addr_word(input logic [FIELD_W-1:0] addr);
      return (addr >> 2) & FIELD_W'((1 << WORD_SEL_W) - 1);
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache: one combinational read
// port and one write port that installs a whole line or updates one word.
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int LINE_W    = 256,
   parameter int TAG_W     = 23,
   parameter int IDX_W     = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [IDX_W-1:0]      index,
   output logic                  valid,
   output logic                  dirty,
   output logic [TAG_W-1:0]      tag,
   output logic [LINE_W-1:0]     line,
   input  logic                  line_we,
   input  logic [LINE_W-1:0]     line_wdata,
   input  logic [TAG_W-1:0]      line_tag,
   input  logic                  word_we,
   input  logic [WORD_SEL_W-1:0] word_sel,
   input  logic [31:0]           word_wdata
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   assign valid = valid_q[index];
   assign dirty = dirty_q[index];
   assign tag   = tag_q[index];
   assign line  = data_q[index];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (word_we) begin
         dirty_q[index] <= 1'b1;
      end
   end

   // NOTE: tag and data arrays carry no reset; a cleared valid bit makes their contents irrelevant.
   always_ff @(posedge clk_i) begin
      if (line_we) begin
         tag_q[index]  <= line_tag;
         data_q[index] <= line_wdata;
      end else if (word_we) begin
         data_q[index][{word_sel, 5'b0} +: 32] <= word_wdata;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller in the
// MEM stage; stalls the pipeline while a miss refills or evicts a line.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int LINE_W    = 256,
   parameter int ADDR_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_read_i,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic [LINE_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

   state_e state_q, state_d;

   logic [FIELD_W-1:0]    tag_x, idx_x, word_x;
   logic [TAG_W-1:0]      req_tag;
   logic [IDX_W-1:0]      req_idx;
   logic [WORD_SEL_W-1:0] req_word;
   logic                  req, hit;
   logic                  rd_valid, rd_dirty;
   logic [TAG_W-1:0]      rd_tag;
   logic [LINE_W-1:0]     rd_line;
   logic                  line_we, word_we;

   assign tag_x    = addr_tag(FIELD_W'(addr_i), IDX_W);
   assign idx_x    = addr_index(FIELD_W'(addr_i), IDX_W);
   assign word_x   = addr_word(FIELD_W'(addr_i));
   assign req_tag  = tag_x[TAG_W-1:0];
   assign req_idx  = idx_x[IDX_W-1:0];
   assign req_word = word_x[WORD_SEL_W-1:0];

   logic unused_bits;
   assign unused_bits = ^{tag_x[FIELD_W-1:TAG_W], idx_x[FIELD_W-1:IDX_W],
                          word_x[FIELD_W-1:WORD_SEL_W], addr_i[1:0]};

   dcache_sram #(
      .NUM_LINES (NUM_LINES),
      .LINE_W    (LINE_W),
      .TAG_W     (TAG_W),
      .IDX_W     (IDX_W)
   ) u_sram (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .index      (req_idx),
      .valid      (rd_valid),
      .dirty      (rd_dirty),
      .tag        (rd_tag),
      .line       (rd_line),
      .line_we    (line_we),
      .line_wdata (mem_rdata_i),
      .line_tag   (req_tag),
      .word_we    (word_we),
      .word_sel   (req_word),
      .word_wdata (wdata_i)
   );

   assign req = req_read_i | req_write_i;
   assign hit = req && rd_valid && (rd_tag == req_tag);

   // A combined read+write still returns the word as it was before the store lands.
   assign rdata_o = hit ? rd_line[{req_word, 5'b0} +: 32] : 32'h0;

   // Stall drops with reset so a frozen pipeline is released even mid-miss.
   assign stall_o = rst_i && ((state_q != IDLE) || (req && !hit));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      line_we      = 1'b0;
      word_we      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req && !hit)
               state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
            else if (req_write_i && hit)
               word_we = 1'b1;
         end
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {rd_tag, req_idx, {OFF_W{1'b0}}};
            mem_wdata_o  = rd_line;
            if (mem_ack_i) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {req_tag, req_idx, {OFF_W{1'b0}}};
            if (mem_ack_i) begin
               line_we = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed plan plus randomized traffic
// against a line-level cache/memory model kept in the bench.
module tb_dcache_ctrl;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         req_read_i, req_write_i;
   logic [31:0]  addr_i, wdata_i, rdata_o;
   logic         stall_o, mem_enable_o, mem_write_o, mem_ack_i;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o, mem_rdata_i;

   dcache_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .req_read_i   (req_read_i),
      .req_write_i  (req_write_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rdata_o      (rdata_o),
      .stall_o      (stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i),
      .mem_ack_i    (mem_ack_i)
   );

   always #5 clk = ~clk;

   // Cache model: per-line state, plus a sparse backing store keyed by line address.
   bit           m_valid [16];
   bit           m_dirty [16];
   logic [22:0]  m_tag   [16];
   logic [255:0] m_data  [16];
   logic [255:0] mem [logic [31:0]];

   // Expected outputs for the current cycle, set by the stimulus thread.
   logic         chk_en = 1'b0;
   logic         exp_stall, exp_en, exp_we, exp_rd_chk;
   logic [31:0]  exp_addr, exp_rdata;
   logic [255:0] exp_wdata;

   int           n_checks = 0, n_pass = 0;
   int           stall_cnt = 0, wb_cnt = 0, alloc_cnt = 0;
   logic [31:0]  last_rdata, last_wb_addr, last_alloc_addr;
   logic [255:0] last_wb_data;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (stall_o) stall_cnt++;
         if (mem_enable_o && mem_write_o) begin
            wb_cnt++;
            last_wb_addr = mem_addr_o;
            last_wb_data = mem_wdata_o;
         end
         if (mem_enable_o && !mem_write_o) begin
            alloc_cnt++;
            last_alloc_addr = mem_addr_o;
         end
         check("stall_o", stall_o, exp_stall);
         check("mem_enable_o", mem_enable_o, exp_en);
         if (exp_en) begin
            check("mem_write_o", mem_write_o, exp_we);
            check("mem_addr_o", mem_addr_o, exp_addr);
            if (exp_we) check("mem_wdata_o", mem_wdata_o, exp_wdata);
         end
         if (exp_rd_chk) begin
            last_rdata = rdata_o;
            check("rdata_o", rdata_o, exp_rdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input logic st, input logic en, input logic we, input logic [31:0] a,
                          input logic [255:0] wd, input logic rc, input logic [31:0] rd);
      exp_stall = st; exp_en = en; exp_we = we; exp_addr = a;
      exp_wdata = wd; exp_rd_chk = rc; exp_rdata = rd;
   endtask

   task automatic touch_line(input logic [31:0] la);
      if (!mem.exists(la))
         mem[la] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   // One complete request, from presentation to the cycle it finishes without stall.
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat);
      int          idx, word;
      logic [22:0] tag;
      logic [31:0] la;
      idx = int'(addr[8:5]); tag = addr[31:9]; word = int'(addr[4:2]);
      req_read_i = rd; req_write_i = wr; addr_i = addr; wdata_i = wd;
      if (!(m_valid[idx] && m_tag[idx] == tag)) begin
         set_exp(1, 0, 0, 0, 0, 0, 0);
         step();
         if (m_dirty[idx]) begin
            la = {m_tag[idx], 4'(idx), 5'b0};
            set_exp(1, 1, 1, la, m_data[idx], 0, 0);
            repeat (lat - 1) step();
            mem_ack_i = 1'b1;
            step();
            mem_ack_i = 1'b0;
            mem[la] = m_data[idx];
         end
         la = {tag, 4'(idx), 5'b0};
         touch_line(la);
         set_exp(1, 1, 0, la, 0, 0, 0);
         repeat (lat - 1) step();
         mem_ack_i = 1'b1;
         mem_rdata_i = mem[la];
         step();
         mem_ack_i = 1'b0;
         mem_rdata_i = {8{$urandom}};
         m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = tag; m_data[idx] = mem[la];
      end
      set_exp(0, 0, 0, 0, 0, 1, m_data[idx][word*32 +: 32]);
      mem_ack_i = ($urandom_range(0, 3) == 0);
      step();
      mem_ack_i = 1'b0;
      if (wr) begin
         m_data[idx][word*32 +: 32] = wd;
         m_dirty[idx] = 1'b1;
      end
      req_read_i = 1'b0; req_write_i = 1'b0;
      set_exp(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic clr_cnt();
      stall_cnt = 0; wb_cnt = 0; alloc_cnt = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [255:0] l;
      rst_i = 1'b0; req_read_i = 1'b0; req_write_i = 1'b0; addr_i = '0; wdata_i = '0;
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = '0; end
      set_exp(0, 0, 0, 0, 0, 0, 0);
      l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      l[95:64] = 32'hDEADBEEF;
      mem[32'h100] = l;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b1;

      @(negedge clk);
      check("rst_stall", stall_o, 0);
      check("rst_mem_enable", mem_enable_o, 0);
      check("rst_mem_write", mem_write_o, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_mem_wdata", mem_wdata_o, 0);
      check("rst_rdata", rdata_o, 0);
      step();
      chk_en = 1'b1;

      // Cold read miss, then a hit on another word of the line.
      clr_cnt();
      do_req(1, 0, 32'h100, 0, 10);
      check("t1_stall_cycles", stall_cnt, 11);
      check("t1_alloc_addr", last_alloc_addr, 32'h100);
      do_req(1, 0, 32'h108, 0, 1);
      check("t1_rdata_108", last_rdata, 32'hDEADBEEF);

      // Write hit: no memory traffic, readback sees the new word.
      clr_cnt();
      do_req(0, 1, 32'h104, 32'h12345678, 1);
      do_req(1, 0, 32'h104, 0, 1);
      check("t2_no_stall", stall_cnt, 0);
      check("t2_no_mem", wb_cnt + alloc_cnt, 0);
      check("t2_rdata_104", last_rdata, 32'h12345678);

      // Dirty eviction at index 8.
      clr_cnt();
      do_req(1, 0, 32'h2104, 0, 10);
      check("t3_stall_cycles", stall_cnt, 21);
      check("t3_wb_cycles", wb_cnt, 10);
      check("t3_wb_addr", last_wb_addr, 32'h100);
      check("t3_wb_word1", last_wb_data[63:32], 32'h12345678);
      check("t3_mem_word1", mem[32'h100][63:32], 32'h12345678);
      check("t3_alloc_addr", last_alloc_addr, 32'h2100);

      // Clean eviction: allocate only.
      clr_cnt();
      do_req(1, 0, 32'h4104, 0, 10);
      check("t4_stall_cycles", stall_cnt, 11);
      check("t4_wb_cycles", wb_cnt, 0);
      check("t4_alloc_cycles", alloc_cnt, 10);
      check("t4_alloc_addr", last_alloc_addr, 32'h4100);

      // Read+write together behaves as a store; the read port shows the old word.
      do_req(1, 1, 32'h108, 32'hA5A5A5A5, 4);
      check("t5_prewrite_rdata", last_rdata, 32'hDEADBEEF);
      do_req(1, 0, 32'h108, 0, 1);
      check("t5_rdata_108", last_rdata, 32'hA5A5A5A5);

      // Reset in the middle of an allocate wait.
      chk_en = 1'b0;
      req_read_i = 1'b1; addr_i = 32'h1200;
      step(); step(); step();
      #2 rst_i = 1'b0;
      #1;
      check("t6_rst_mem_enable", mem_enable_o, 0);
      check("t6_rst_stall", stall_o, 0);
      step();
      rst_i = 1'b1;
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
      clr_cnt();
      chk_en = 1'b1;
      do_req(1, 0, 32'h1200, 0, 3);
      check("t6_remiss_stall", stall_cnt, 4);
      check("t6_remiss_alloc", last_alloc_addr, 32'h1200);

      // Randomized traffic over a few aliasing tags per index.
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         int op;
         a = {21'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 2'b00};
         op = $urandom_range(0, 3);
         do_req(op != 1, op == 1 || op == 2, a, $urandom, $urandom_range(1, 6));
         if ($urandom_range(0, 2) == 0) step();
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
